// File: rtl/hash_writeback.sv
// Captures the 512-bit Keccak digest and commits it to OCM as four 128-bit
// single-beat writes, using the burst master's init/active/done handshake.
module hash_writeback #(
    parameter int HASH_BITS = 512,
    parameter int BEAT_BITS = 128,
    parameter int IDX_W     = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 out_ready,
    input  logic [HASH_BITS-1:0] keccak_hash_reg,
    input  logic [IDX_W-1:0]     base_addr_index,
    input  logic                 write_ready,
    output logic                 init_write_txn,
    output logic [BEAT_BITS-1:0] write_data,
    output logic [IDX_W-1:0]     write_addr_index,
    input  logic                 write_active,
    input  logic                 write_done,
    output logic                 done,
    output logic [31:0]          debug
);

    localparam int NUM_BEATS = HASH_BITS / BEAT_BITS;
    localparam int BI_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARMED     = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_ACT  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                                state_q, state_d;
    logic [NUM_BEATS-1:0][BEAT_BITS-1:0]   shadow_q, shadow_d;
    logic [2:0]                            beat_cnt_q, beat_cnt_d;
    logic [BEAT_BITS-1:0]                  wr_data_q, wr_data_d;
    logic [IDX_W-1:0]                      wr_addr_q, wr_addr_d;
    logic                                  init_q, init_d;
    logic                                  done_q, done_d;
    logic                                  beat_complete;
    logic [BI_W-1:0]                       next_beat_idx;

    assign next_beat_idx = beat_cnt_q[BI_W-1:0] + BI_W'(1);

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        beat_cnt_d    = beat_cnt_q;
        wr_data_d     = wr_data_q;
        wr_addr_d     = wr_addr_q;
        init_d        = 1'b0;
        done_d        = done_q;
        beat_complete = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    done_d     = 1'b0;
                    wr_addr_d  = base_addr_index;
                    beat_cnt_d = 3'd0;
                    state_d    = S_ARMED;
                end
            end
            S_ARMED: begin
                if (out_ready) begin
                    shadow_d  = keccak_hash_reg;
                    wr_data_d = keccak_hash_reg[BEAT_BITS-1:0];
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (write_ready) begin
                    init_d  = 1'b1;
                    state_d = S_WAIT_ACT;
                end
            end
            S_WAIT_ACT: begin
                // A done seen here (with or ahead of active) already closes the beat.
                if (write_done)        beat_complete = 1'b1;
                else if (write_active) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (write_done) beat_complete = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (beat_complete) begin
            beat_cnt_d = beat_cnt_q + 3'd1;
            wr_addr_d  = wr_addr_q + IDX_W'(1);
            if (beat_cnt_q == 3'(NUM_BEATS - 1)) begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end else begin
                // Preload the next beat so data is stable before its init pulse.
                wr_data_d = shadow_q[next_beat_idx];
                state_d   = S_ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            shadow_q   <= '0;
            beat_cnt_q <= 3'd0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            init_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            beat_cnt_q <= beat_cnt_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
            init_q     <= init_d;
            done_q     <= done_d;
        end
    end

    assign init_write_txn   = init_q;
    assign write_data       = wr_data_q;
    assign write_addr_index = wr_addr_q;
    assign done             = done_q;
    assign debug            = {24'b0, 1'b0, beat_cnt_q, 1'b0, state_q};

endmodule

// File: tb/tb_hash_writeback.sv
// Randomized bench: start issues push expected beats into a scoreboard; a
// write-master BFM pops and compares on every init pulse and checks handshakes.
module tb_hash_writeback;

    logic         clk = 1'b0;
    logic         resetn, start, out_ready, write_ready, write_active, write_done;
    logic [511:0] keccak_hash_reg;
    logic [31:0]  base_addr_index;
    logic         init_write_txn, done;
    logic [127:0] write_data;
    logic [31:0]  write_addr_index, debug;

    hash_writeback dut (
        .clk(clk), .resetn(resetn), .start(start), .out_ready(out_ready),
        .keccak_hash_reg(keccak_hash_reg), .base_addr_index(base_addr_index),
        .write_ready(write_ready), .init_write_txn(init_write_txn),
        .write_data(write_data), .write_addr_index(write_addr_index),
        .write_active(write_active), .write_done(write_done),
        .done(done), .debug(debug)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0, failures = 0;

    // BFM configuration, written by the main sequence
    int act_dly = 1, done_dly = 2, stall_len = 0;
    bit together = 0;

    // BFM status, read by the main sequence
    int    pulses = 0, first_pulse_cyc = 0, t = 0, stall_cnt = 0;
    bit    busy = 0, cur_last = 0, done_chk = 0, pulse_due = 0;
    beat_t cur;
    int    start_cyc = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] d = '0;
        for (int i = 0; i < 16; i++) d = {d[479:0], 32'($urandom())};
        return d;
    endfunction

    // Reference model: four beats, little-endian slices, consecutive wrapping addresses
    task automatic do_start(input logic [31:0] base, input logic [511:0] digest);
        beat_t b;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            b.addr = base + 32'(i);
            b.data = 128'(digest >> (128 * i));
            exp_q.push_back(b);
        end
        start = 1'b1; base_addr_index = base; keccak_hash_reg = digest;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", done, 1'b1);
        @(negedge clk);
        chk("scoreboard_drained", 512'(exp_q.size()), 512'd0);
    endtask

    // Write-master BFM and monitor, all sampling/driving on the falling edge
    initial begin
        write_ready = 1'b1; write_active = 1'b0; write_done = 1'b0;
        forever begin
            @(negedge clk);
            write_active = 1'b0;
            write_done   = 1'b0;
            if (!resetn) begin
                busy = 0; stall_cnt = 0; done_chk = 0; pulse_due = 0;
                exp_q.delete();
                write_ready = 1'b1;
                continue;
            end
            if (done_chk) begin
                chk("done_one_cycle_after_last", done, 1'b1);
                done_chk = 0;
            end
            if (pulse_due) begin
                chk("pulse_after_ready_rise", init_write_txn, 1'b1);
                pulse_due = 0;
            end
            if (busy) begin
                chk("no_pulse_while_busy", init_write_txn, 1'b0);
                chk("data_stable", write_data, cur.data);
                chk("addr_stable", write_addr_index, cur.addr);
                t++;
                if (t == act_dly) begin
                    write_active = 1'b1;
                    if (together) write_done = 1'b1;
                end
                if (!together && t == act_dly + done_dly) write_done = 1'b1;
                if (write_done) begin
                    busy = 0;
                    if (cur_last) begin
                        chk("done_low_at_last_done", done, 1'b0);
                        done_chk = 1;
                    end
                    if (stall_len > 0 && exp_q.size() == 2) stall_cnt = stall_len;
                    else write_ready = 1'b1;
                end
            end else if (stall_cnt > 0) begin
                chk("no_pulse_while_not_ready", init_write_txn, 1'b0);
                chk("stall_data", write_data, exp_q[0].data);
                chk("stall_addr", write_addr_index, exp_q[0].addr);
                stall_cnt--;
                if (stall_cnt == 0) begin
                    write_ready = 1'b1;
                    pulse_due   = 1;
                end
            end else if (init_write_txn) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_pulse: got pulse addr=%0h expected none", write_addr_index);
                end else begin
                    cur = exp_q.pop_front();
                    if (exp_q.size() == 3) first_pulse_cyc = cyc;
                    chk("beat_addr", write_addr_index, cur.addr);
                    chk("beat_data", write_data, cur.data);
                    cur_last    = (exp_q.size() == 0);
                    busy        = 1; t = 0;
                    write_ready = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [511:0] ramp, d;
        int p0, n;
        resetn = 1'b1; start = 1'b0; out_ready = 1'b0;
        keccak_hash_reg = '0; base_addr_index = '0;
        #1 resetn = 1'b0;
        #3;
        chk("rst_init", init_write_txn, 1'b0);
        chk("rst_data", write_data, 128'd0);
        chk("rst_addr", write_addr_index, 32'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_debug", debug, 32'd0);
        @(negedge clk); resetn = 1'b1;

        // byte ramp 0x01..0x40, MSB first; out_ready arrives late
        ramp = '0;
        for (int i = 0; i < 64; i++) ramp = {ramp[503:0], 8'(i + 1)};
        p0 = pulses;
        do_start(32'h10, ramp);
        repeat (19) @(negedge clk);
        out_ready = 1'b1;
        wait_done(500);
        chk("ramp_pulse_count", 512'(pulses - p0), 512'd4);
        chk("debug_beat_cnt", debug[6:4], 3'd4);
        out_ready = 1'b0;

        // digest already valid at start: first pulse two clocks after start is sampled
        out_ready = 1'b1;
        p0 = pulses;
        do_start($urandom(), rand512());
        wait_done(500);
        chk("start_to_first_pulse", 512'(first_pulse_cyc - start_cyc), 512'd3);
        chk("early_pulse_count", 512'(pulses - p0), 512'd4);

        // write_ready low for 50 cycles ahead of beat 2
        stall_len = 50;
        do_start($urandom(), rand512());
        wait_done(1000);
        stall_len = 0;

        // active and done together every beat
        together = 1; act_dly = 2;
        p0 = pulses;
        do_start($urandom(), rand512());
        wait_done(500);
        chk("together_pulse_count", 512'(pulses - p0), 512'd4);
        together = 0; act_dly = 1;

        // reset dropped in WAIT_DONE of beat 1
        done_dly = 4;
        do_start($urandom(), rand512());
        n = 0;
        while (!(busy && exp_q.size() == 2 && t > act_dly && t < act_dly + done_dly - 1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wait_done_beat1", 512'(n < 500), 512'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_init", init_write_txn, 1'b0);
        chk("async_rst_data", write_data, 128'd0);
        chk("async_rst_addr", write_addr_index, 32'd0);
        chk("async_rst_done", done, 1'b0);
        chk("async_rst_debug", debug, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        p0 = pulses;
        repeat (100) @(negedge clk);
        chk("no_pulse_after_reset", 512'(pulses - p0), 512'd0);
        chk("done_low_after_reset", done, 1'b0);
        done_dly = 2;
        do_start($urandom(), rand512());
        wait_done(500);

        // address wrap, then re-arm from DONE with a new digest
        do_start(32'hFFFF_FFFE, rand512());
        wait_done(500);
        d = rand512();
        do_start($urandom(), d);
        chk("done_cleared_on_restart", done, 1'b0);
        wait_done(500);

        // a few random handshake timings
        for (int r = 0; r < 3; r++) begin
            act_dly  = int'($urandom_range(1, 3));
            done_dly = int'($urandom_range(1, 4));
            together = bit'($urandom_range(0, 1));
            do_start($urandom(), rand512());
            wait_done(800);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
